// File: rtl/efx_mixed_width_ram_tdp_be.sv
// True-dual-port mixed-width block RAM: narrow port A, RATIO-times-wider port B with lane
// byte enables, per-port read-during-write mode, optional output register and valid strobes.
module efx_mixed_width_ram_tdp_be #(
  parameter int    DATA_WIDTH_A    = 8,
  parameter int    RATIO           = 4,
  parameter int    ADDRESS_WIDTH_A = 10,
  parameter int    OUTREG_A        = 0,
  parameter int    OUTREG_B        = 0,
  parameter string WRITE_MODE_A    = "READ_FIRST",
  parameter string WRITE_MODE_B    = "READ_FIRST",
  localparam int   ADDRESS_WIDTH_B = ADDRESS_WIDTH_A - $clog2(RATIO),
  localparam int   DATA_WIDTH_B    = DATA_WIDTH_A * RATIO
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_a,
  input  logic                       en_b,
  input  logic                       we_a,
  input  logic                       we_b,
  input  logic [RATIO-1:0]           be_b,
  input  logic [ADDRESS_WIDTH_A-1:0] addr_a,
  input  logic [ADDRESS_WIDTH_B-1:0] addr_b,
  input  logic [DATA_WIDTH_A-1:0]    data_in_a,
  input  logic [DATA_WIDTH_B-1:0]    data_in_b,
  output logic [DATA_WIDTH_A-1:0]    data_out_a,
  output logic [DATA_WIDTH_B-1:0]    data_out_b,
  output logic                       valid_a,
  output logic                       valid_b,
  output logic                       collision
);

  localparam int LANE_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH_B   = 1 << ADDRESS_WIDTH_B;
  localparam bit A_WF      = (WRITE_MODE_A == "WRITE_FIRST");
  localparam bit A_NC      = (WRITE_MODE_A == "NO_CHANGE");
  localparam bit B_WF      = (WRITE_MODE_B == "WRITE_FIRST");
  localparam bit B_NC      = (WRITE_MODE_B == "NO_CHANGE");

  logic [ADDRESS_WIDTH_B-1:0] w_a_word;
  logic [LANE_BITS-1:0]       w_a_lane;
  logic                       w_wr_a;
  logic                       w_b_wreq;
  logic                       w_wr_b;
  logic                       w_acc_a;
  logic                       w_acc_b;

  generate
    if (RATIO > 1) begin : g_split
      assign w_a_word = addr_a[ADDRESS_WIDTH_A-1:LANE_BITS];
      assign w_a_lane = addr_a[LANE_BITS-1:0];
    end else begin : g_nosplit
      assign w_a_word = addr_a;
      assign w_a_lane = '0;
    end
  endgenerate

  // Writes are blocked while reset is held; reads still flow but their valids are cleared.
  assign w_wr_a   = rst_n & en_a & we_a;
  assign w_b_wreq = we_b & (|be_b);
  assign w_wr_b   = rst_n & en_b & w_b_wreq;
  assign w_acc_a  = en_a & ~(we_a & A_NC);
  assign w_acc_b  = en_b & ~(w_b_wreq & B_NC);

  logic [RATIO-1:0][DATA_WIDTH_A-1:0] w_rd_a;
  logic [RATIO-1:0][DATA_WIDTH_A-1:0] w_rd_b;

  // One narrow RAM per lane; B is written after A so B wins a same-lane dual write.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam logic [LANE_BITS-1:0] LANE_ID = LANE_BITS'(gi);
      logic [DATA_WIDTH_A-1:0] r_mem [DEPTH_B];
      logic [DATA_WIDTH_A-1:0] r_rd_a;
      logic [DATA_WIDTH_A-1:0] r_rd_b;

      always_ff @(posedge clk) begin
        if (w_wr_a && (w_a_lane == LANE_ID)) r_mem[w_a_word] <= data_in_a;
        if (w_wr_b && be_b[gi]) r_mem[addr_b] <= data_in_b[gi*DATA_WIDTH_A +: DATA_WIDTH_A];
        if (en_a) r_rd_a <= r_mem[w_a_word];
        if (en_b) r_rd_b <= r_mem[addr_b];
      end

      assign w_rd_a[gi] = r_rd_a;
      assign w_rd_b[gi] = r_rd_b;
    end
  endgenerate

  logic                    r_a_acc1;
  logic                    r_a_wr1;
  logic [LANE_BITS-1:0]    r_a_lane1;
  logic [DATA_WIDTH_A-1:0] r_a_wdata1;
  logic                    r_b_acc1;
  logic                    r_b_wr1;
  logic [RATIO-1:0]        r_b_be1;
  logic [DATA_WIDTH_B-1:0] r_b_wdata1;
  logic                    r_collision;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_acc1    <= 1'b0;
      r_a_wr1     <= 1'b0;
      r_a_lane1   <= '0;
      r_a_wdata1  <= '0;
      r_b_acc1    <= 1'b0;
      r_b_wr1     <= 1'b0;
      r_b_be1     <= '0;
      r_b_wdata1  <= '0;
      r_collision <= 1'b0;
    end else begin
      r_a_acc1    <= w_acc_a;
      r_a_wr1     <= w_wr_a;
      r_a_lane1   <= w_a_lane;
      r_a_wdata1  <= data_in_a;
      r_b_acc1    <= w_acc_b;
      r_b_wr1     <= w_wr_b;
      r_b_be1     <= be_b;
      r_b_wdata1  <= data_in_b;
      r_collision <= w_wr_a & w_wr_b & (w_a_word == addr_b) & be_b[w_a_lane];
    end
  end

  logic [DATA_WIDTH_A-1:0] w_a_data;
  logic [DATA_WIDTH_B-1:0] w_b_data;

  // Write-first on B merges new data into enabled lanes over the old word.
  always_comb begin
    w_a_data = w_rd_a[r_a_lane1];
    if (A_WF && r_a_wr1) w_a_data = r_a_wdata1;
    w_b_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_b_data[i*DATA_WIDTH_A +: DATA_WIDTH_A] = (B_WF && r_b_wr1 && r_b_be1[i]) ?
          r_b_wdata1[i*DATA_WIDTH_A +: DATA_WIDTH_A] : w_rd_b[i];
    end
  end

  logic                    r_a_v2;
  logic                    r_a_v3;
  logic [DATA_WIDTH_A-1:0] r_a_d2;
  logic [DATA_WIDTH_A-1:0] r_a_d3;
  logic                    r_b_v2;
  logic                    r_b_v3;
  logic [DATA_WIDTH_B-1:0] r_b_d2;
  logic [DATA_WIDTH_B-1:0] r_b_d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_v2 <= 1'b0;
      r_a_v3 <= 1'b0;
      r_a_d2 <= '0;
      r_a_d3 <= '0;
      r_b_v2 <= 1'b0;
      r_b_v3 <= 1'b0;
      r_b_d2 <= '0;
      r_b_d3 <= '0;
    end else begin
      r_a_v2 <= r_a_acc1;
      r_a_v3 <= r_a_v2;
      if (r_a_acc1) r_a_d2 <= w_a_data;
      if (r_a_v2)   r_a_d3 <= r_a_d2;
      r_b_v2 <= r_b_acc1;
      r_b_v3 <= r_b_v2;
      if (r_b_acc1) r_b_d2 <= w_b_data;
      if (r_b_v2)   r_b_d3 <= r_b_d2;
    end
  end

  assign data_out_a = (OUTREG_A != 0) ? r_a_d3 : r_a_d2;
  assign valid_a    = (OUTREG_A != 0) ? r_a_v3 : r_a_v2;
  assign data_out_b = (OUTREG_B != 0) ? r_b_d3 : r_b_d2;
  assign valid_b    = (OUTREG_B != 0) ? r_b_v3 : r_b_v2;
  assign collision  = r_collision;

endmodule

// File: tb/tb_efx_mixed_width_ram_tdp_be.sv
// Directed bench: three RAM instances (read-first/no-outreg, write-first/outreg, no-change)
// share one stimulus stream and are compared against hand-computed values.
module tb_efx_mixed_width_ram_tdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b, we_a, we_b;
  logic [3:0]  be_b;
  logic [9:0]  addr_a;
  logic [7:0]  addr_b;
  logic [7:0]  data_in_a;
  logic [31:0] data_in_b;

  logic [7:0]  rf_dout_a, wf_dout_a, nc_dout_a;
  logic [31:0] rf_dout_b, wf_dout_b, nc_dout_b;
  logic        rf_valid_a, wf_valid_a, nc_valid_a;
  logic        rf_valid_b, wf_valid_b, nc_valid_b;
  logic        rf_collision, wf_collision, nc_collision;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  efx_mixed_width_ram_tdp_be #(
    .OUTREG_A(0), .OUTREG_B(0), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST")
  ) u_rf (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b), .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(rf_dout_a), .data_out_b(rf_dout_b), .valid_a(rf_valid_a), .valid_b(rf_valid_b),
    .collision(rf_collision)
  );

  efx_mixed_width_ram_tdp_be #(
    .OUTREG_A(1), .OUTREG_B(1), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST")
  ) u_wf (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b), .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(wf_dout_a), .data_out_b(wf_dout_b), .valid_a(wf_valid_a), .valid_b(wf_valid_b),
    .collision(wf_collision)
  );

  efx_mixed_width_ram_tdp_be #(
    .OUTREG_A(0), .OUTREG_B(0), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE")
  ) u_nc (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b), .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(nc_dout_a), .data_out_b(nc_dout_b), .valid_a(nc_valid_a), .valid_b(nc_valid_b),
    .collision(nc_collision)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; be_b = 4'b0000;
  endtask

  function automatic int stream_idx(input int c);
    if (c < 8)       return c;
    else if (c == 8) return -1;
    else if (c <= 16) return c - 1;
    else             return -1;
  endfunction

  function automatic logic [7:0] stream_val(input int i);
    return 8'(8'h30 + i * 5);
  endfunction

  initial begin
    int          k;
    int          pulses;
    logic        exp_v;
    logic [7:0]  last_d;

    rst_n = 1'b0;
    idle();
    addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;
    tick(); tick();
    check("rst_dout_a", 32'(rf_dout_a), 32'd0);
    check("rst_dout_b", rf_dout_b, 32'd0);
    check("rst_valid_a", 32'(rf_valid_a), 32'd0);
    check("rst_valid_b", 32'(rf_valid_b), 32'd0);
    check("rst_collision", 32'(rf_collision), 32'd0);
    check("rst_wf_dout_b", wf_dout_b, 32'd0);
    rst_n = 1'b1;
    tick();

    // Width mapping: four narrow writes assemble one wide word
    for (int i = 0; i < 4; i++) begin
      en_a = 1'b1; we_a = 1'b1; addr_a = 10'(10'h010 + i); data_in_a = 8'(8'h11 * (i + 1));
      tick();
    end
    idle();
    tick(); tick();
    check("wf_a_write_first", 32'(wf_dout_a), 32'h44);
    check("wf_a_write_valid", 32'(wf_valid_a), 32'd1);
    en_b = 1'b1; addr_b = 8'h04;
    tick();
    idle();
    check("rf_b_lat_not0", 32'(rf_valid_b), 32'd0);
    tick();
    check("rf_b_map", rf_dout_b, 32'h44332211);
    check("rf_b_valid", 32'(rf_valid_b), 32'd1);
    check("wf_b_lat2_early", 32'(wf_valid_b), 32'd0);
    check("nc_b_map", nc_dout_b, 32'h44332211);
    tick();
    check("wf_b_map", wf_dout_b, 32'h44332211);
    check("wf_b_valid", 32'(wf_valid_b), 32'd1);
    check("rf_b_valid_pulse", 32'(rf_valid_b), 32'd0);
    check("rf_b_hold", rf_dout_b, 32'h44332211);

    // Byte-enabled write on B, read-during-write per mode
    en_b = 1'b1; we_b = 1'b1; be_b = 4'b0101; addr_b = 8'h04; data_in_b = 32'hAABBCCDD;
    tick();
    idle();
    tick();
    check("rf_be_old", rf_dout_b, 32'h44332211);
    check("rf_be_valid", 32'(rf_valid_b), 32'd1);
    check("nc_be_novalid", 32'(nc_valid_b), 32'd0);
    check("nc_be_hold", nc_dout_b, 32'h44332211);
    tick();
    check("wf_be_merged", wf_dout_b, 32'h44BB22DD);
    check("wf_be_valid", 32'(wf_valid_b), 32'd1);
    en_a = 1'b1; addr_a = 10'h011; en_b = 1'b1; addr_b = 8'h04;
    tick();
    idle();
    tick();
    check("rf_a_lane1", 32'(rf_dout_a), 32'h22);
    check("rf_b_after_be", rf_dout_b, 32'h44BB22DD);
    tick();
    check("wf_a_lane1", 32'(wf_dout_a), 32'h22);

    // Read-during-write on a full-word B write
    en_b = 1'b1; we_b = 1'b1; be_b = 4'hF; addr_b = 8'h07; data_in_b = 32'h12345678;
    tick();
    idle();
    tick(); tick();
    en_b = 1'b1; we_b = 1'b1; be_b = 4'hF; addr_b = 8'h07; data_in_b = 32'hCAFEF00D;
    tick();
    idle();
    tick();
    check("rf_rdw", rf_dout_b, 32'h12345678);
    check("nc_rdw_novalid", 32'(nc_valid_b), 32'd0);
    check("nc_rdw_hold", nc_dout_b, 32'h44BB22DD);
    tick();
    check("wf_rdw", wf_dout_b, 32'hCAFEF00D);
    check("wf_rdw_valid", 32'(wf_valid_b), 32'd1);
    en_b = 1'b1; we_b = 1'b1; be_b = 4'b0000; addr_b = 8'h07; data_in_b = 32'h0;
    tick();
    idle();
    tick();
    check("nc_be0_is_read_v", 32'(nc_valid_b), 32'd1);
    check("nc_be0_is_read_d", nc_dout_b, 32'hCAFEF00D);

    // Same-lane dual write: B wins, collision pulses once
    en_a = 1'b1; we_a = 1'b1; addr_a = 10'h01C; data_in_a = 8'h55;
    en_b = 1'b1; we_b = 1'b1; be_b = 4'b0001; addr_b = 8'h07; data_in_b = 32'hDEADBEEF;
    tick();
    idle();
    check("collision_hi", 32'(rf_collision), 32'd1);
    tick();
    check("collision_pulse", 32'(rf_collision), 32'd0);
    check("coll_a_old", 32'(rf_dout_a), 32'h0D);
    check("coll_b_old", rf_dout_b, 32'hCAFEF00D);
    en_a = 1'b1; addr_a = 10'h01C; en_b = 1'b1; addr_b = 8'h07;
    tick();
    idle();
    tick();
    check("coll_b_wins", 32'(rf_dout_a), 32'hEF);
    check("coll_word", rf_dout_b, 32'hCAFEF0EF);
    // Cross-port: A reads a lane that B writes in the same cycle
    en_a = 1'b1; addr_a = 10'h01D;
    en_b = 1'b1; we_b = 1'b1; be_b = 4'b0010; addr_b = 8'h07; data_in_b = 32'h00009900;
    tick();
    idle();
    check("xport_no_coll", 32'(rf_collision), 32'd0);
    tick();
    check("xport_a_old", 32'(rf_dout_a), 32'hF0);
    en_a = 1'b1; addr_a = 10'h01D;
    tick();
    idle();
    tick();
    check("xport_a_new", 32'(rf_dout_a), 32'h99);
    // Same word, different lanes: no collision
    en_a = 1'b1; we_a = 1'b1; addr_a = 10'h01F; data_in_a = 8'hCA;
    en_b = 1'b1; we_b = 1'b1; be_b = 4'b0100; addr_b = 8'h07; data_in_b = 32'h00FE0000;
    tick();
    idle();
    check("difflane_no_coll", 32'(rf_collision), 32'd0);

    // Streaming reads through the registered A port with a one-cycle gap
    for (int i = 0; i < 16; i++) begin
      en_a = 1'b1; we_a = 1'b1; addr_a = 10'(10'h100 + i); data_in_a = stream_val(i);
      tick();
    end
    idle();
    tick(); tick(); tick();
    pulses = 0;
    last_d = 8'h00;
    for (int c = 0; c < 20; c++) begin
      if (stream_idx(c) >= 0) begin
        en_a = 1'b1; we_a = 1'b0; addr_a = 10'(10'h100 + stream_idx(c));
      end else begin
        idle();
      end
      tick();
      k = c - 2;
      exp_v = (k >= 0) && (stream_idx(k) >= 0);
      if (wf_valid_a) pulses++;
      check($sformatf("stream_v_c%0d", c), 32'(wf_valid_a), 32'(exp_v));
      if (k >= 0) begin
        if (exp_v) last_d = stream_val(stream_idx(k));
        check($sformatf("stream_d_c%0d", c), 32'(wf_dout_a), 32'(last_d));
      end
    end
    idle();
    check("stream_pulses", 32'(pulses), 32'd16);

    // Reset with two B reads in flight on the registered port
    en_b = 1'b1; addr_b = 8'h07;
    tick();
    en_b = 1'b1; addr_b = 8'h04;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_wf_dout_b", wf_dout_b, 32'd0);
    check("midrst_wf_valid_b", 32'(wf_valid_b), 32'd0);
    check("midrst_rf_dout_b", rf_dout_b, 32'd0);
    check("midrst_rf_valid_b", 32'(rf_valid_b), 32'd0);
    en_a = 1'b1; we_a = 1'b1; addr_a = 10'h01C; data_in_a = 8'h77;
    tick(); tick();
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("postrst_wf_v%0d", c), 32'(wf_valid_b), 32'd0);
      check($sformatf("postrst_rf_v%0d", c), 32'(rf_valid_b), 32'd0);
    end
    en_a = 1'b1; addr_a = 10'h01C; en_b = 1'b1; addr_b = 8'h07;
    tick();
    idle();
    tick();
    check("rst_write_blocked", 32'(rf_dout_a), 32'hEF);
    check("rst_mem_kept_rf", rf_dout_b, 32'hCAFE99EF);
    tick();
    check("rst_mem_kept_wf", wf_dout_b, 32'hCAFE99EF);
    check("rst_reread_valid", 32'(wf_valid_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
